// File: rtl/ondra_mem_pkg.sv
// Shared types for the Ondra SDRAM arbiter: FSM states, transfer owners and the
// VRAM window base used to place video fetches in the SDRAM map.
package ondra_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      DONE
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_VID,
      OWN_LDR,
      OWN_CPU
   } owner_t;

   localparam logic [1:0] VRAM_BASE = 2'b11;

endpackage

// File: rtl/ondra_arb_prio.sv
// Winner select for the SDRAM port (video > loader > CPU) with a burst counter
// that hands the CPU a turn after VID_BURST_MAX video grants while it waits.
module ondra_arb_prio
   import ondra_mem_pkg::*;
#(
   parameter int VID_BURST_MAX = 4
)(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       vid_req_i,
   input  logic       ldr_req_i,
   input  logic       cpu_req_i,
   input  logic       sample_i,
   output logic       grant_o,
   output logic [1:0] owner_o
);

   localparam logic [3:0] BURST_LIM = 4'(VID_BURST_MAX);

   logic [3:0] burst_q, burst_d;
   owner_t     win;

   always_comb begin
      win     = OWN_CPU;
      grant_o = vid_req_i | ldr_req_i | cpu_req_i;
      burst_d = burst_q;

      if (cpu_req_i && (burst_q == BURST_LIM)) begin
         win = OWN_CPU;
      end else if (vid_req_i) begin
         win = OWN_VID;
      end else if (ldr_req_i) begin
         win = OWN_LDR;
      end

      // Only video grants made while the CPU is stalled count towards its turn.
      if (!cpu_req_i) begin
         burst_d = '0;
      end else if (sample_i) begin
         if (win == OWN_CPU) begin
            burst_d = '0;
         end else if ((win == OWN_VID) && (burst_q != 4'hF)) begin
            burst_d = burst_q + 4'd1;
         end
      end

      owner_o = win;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/ondra_mem_arbiter.sv
// Ondra SDRAM byte-port arbiter: one transfer at a time, IDLE->ISSUE->WAIT_ACK->DONE.
// Optional transfer statistics are built when ONDRA_ARB_STATS_EN is defined.
module ondra_mem_arbiter
   import ondra_mem_pkg::*;
#(
   parameter int ADDR_W        = 23,
   parameter int VID_BURST_MAX = 4,
   parameter int ACK_TIMEOUT   = 255
)(
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              vid_req_i,
   input  logic [13:0]       vid_addr_i,
   output logic              vid_ack_o,
   output logic [7:0]        vid_dout_o,
   input  logic              ldr_req_i,
   input  logic [ADDR_W-1:0] ldr_addr_i,
   input  logic [7:0]        ldr_din_i,
   output logic              ldr_ack_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [15:0]       cpu_addr_i,
   input  logic [7:0]        cpu_din_i,
   output logic [7:0]        cpu_dout_o,
   output logic              cpu_ack_o,
   output logic              cpu_wait_n_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_din_o,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_dout_i,
   output logic              err_timeout_o
`ifdef ONDRA_ARB_STATS_EN
   ,
   input  logic              stat_clr_i,
   output logic [15:0]       stat_cpu_stall_o,
   output logic [15:0]       stat_vid_grants_o
`endif
);

   localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              we_q, we_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        vid_dout_q, vid_dout_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic              err_q, err_d;
   logic              grant;
   logic [1:0]        win_raw;
   owner_t            win;
   logic [7:0]        rdata;

   ondra_arb_prio #(
      .VID_BURST_MAX(VID_BURST_MAX)
   ) u_prio (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .vid_req_i(vid_req_i),
      .ldr_req_i(ldr_req_i),
      .cpu_req_i(cpu_req_i),
      .sample_i (state_q == IDLE),
      .grant_o  (grant),
      .owner_o  (win_raw)
   );

   assign win = owner_t'(win_raw);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      din_d      = din_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      vid_dout_d = vid_dout_q;
      cpu_dout_d = cpu_dout_q;
      err_d      = err_q;
      // An aborted transfer returns 0xFF to its owner in place of real data.
      rdata      = mem_ack_i ? mem_dout_i : 8'hFF;

      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ISSUE;
               owner_d = win;
               case (win)
                  OWN_VID: begin
                     addr_d = ADDR_W'({VRAM_BASE, vid_addr_i});
                     we_d   = 1'b0;
                     din_d  = 8'h00;
                  end
                  OWN_LDR: begin
                     addr_d = ldr_addr_i;
                     we_d   = 1'b1;
                     din_d  = ldr_din_i;
                  end
                  default: begin
                     addr_d = ADDR_W'(cpu_addr_i);
                     we_d   = cpu_we_i;
                     din_d  = cpu_din_i;
                  end
               endcase
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (mem_ack_i || (cnt_q == TMO)) begin
               state_d = DONE;
               if (!mem_ack_i) begin
                  err_d = 1'b1;
               end
               if (owner_q == OWN_VID) begin
                  vid_dout_d = rdata;
               end else if (owner_q == OWN_CPU) begin
                  cpu_dout_d = rdata;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_VID;
         addr_q     <= '0;
         din_q      <= 8'h00;
         we_q       <= 1'b0;
         cnt_q      <= 8'd0;
         vid_dout_q <= 8'h00;
         cpu_dout_q <= 8'h00;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         vid_dout_q <= vid_dout_d;
         cpu_dout_q <= cpu_dout_d;
         err_q      <= err_d;
      end
   end

   assign mem_req_o     = (state_q == ISSUE);
   assign mem_we_o      = we_q;
   assign mem_addr_o    = addr_q;
   assign mem_din_o     = din_q;
   assign vid_ack_o     = (state_q == DONE) && (owner_q == OWN_VID);
   assign ldr_ack_o     = (state_q == DONE) && (owner_q == OWN_LDR);
   assign cpu_ack_o     = (state_q == DONE) && (owner_q == OWN_CPU);
   assign vid_dout_o    = vid_dout_q;
   assign cpu_dout_o    = cpu_dout_q;
   assign err_timeout_o = err_q;
   // Releases in the ack cycle itself so the Z80 sees data and resumes together.
   assign cpu_wait_n_o  = ~cpu_req_i | cpu_ack_o;

`ifdef ONDRA_ARB_STATS_EN
   logic [15:0] stall_q, vgrant_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         stall_q  <= 16'h0000;
         vgrant_q <= 16'h0000;
      end else if (stat_clr_i) begin
         stall_q  <= 16'h0000;
         vgrant_q <= 16'h0000;
      end else begin
         if (!cpu_wait_n_o && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if ((state_q == IDLE) && grant && (win == OWN_VID) && (vgrant_q != 16'hFFFF)) begin
            vgrant_q <= vgrant_q + 16'd1;
         end
      end
   end

   assign stat_cpu_stall_o  = stall_q;
   assign stat_vid_grants_o = vgrant_q;
`endif

endmodule

// File: tb/tb_ondra_mem_arbiter.sv
// Scoreboard bench for ondra_mem_arbiter: expected transfers are queued as requests
// are raised and checked at mem_req (command) and at the owner's ack (completion).
module tb_ondra_mem_arbiter;

   logic        clk_sys;
   logic        reset;
   logic        vid_req_i;
   logic [13:0] vid_addr_i;
   logic        vid_ack_o;
   logic [7:0]  vid_dout_o;
   logic        ldr_req_i;
   logic [22:0] ldr_addr_i;
   logic [7:0]  ldr_din_i;
   logic        ldr_ack_o;
   logic        cpu_req_i;
   logic        cpu_we_i;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_din_i;
   logic [7:0]  cpu_dout_o;
   logic        cpu_ack_o;
   logic        cpu_wait_n_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [22:0] mem_addr_o;
   logic [7:0]  mem_din_o;
   logic        mem_ack_i;
   logic [7:0]  mem_dout_i;
   logic        err_timeout_o;

   ondra_mem_arbiter dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .vid_req_i    (vid_req_i),
      .vid_addr_i   (vid_addr_i),
      .vid_ack_o    (vid_ack_o),
      .vid_dout_o   (vid_dout_o),
      .ldr_req_i    (ldr_req_i),
      .ldr_addr_i   (ldr_addr_i),
      .ldr_din_i    (ldr_din_i),
      .ldr_ack_o    (ldr_ack_o),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_din_i    (cpu_din_i),
      .cpu_dout_o   (cpu_dout_o),
      .cpu_ack_o    (cpu_ack_o),
      .cpu_wait_n_o (cpu_wait_n_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_din_o    (mem_din_o),
      .mem_ack_i    (mem_ack_i),
      .mem_dout_i   (mem_dout_i),
      .err_timeout_o(err_timeout_o)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          own;
      logic [22:0] addr;
      logic        we;
      logic [7:0]  din;
      logic [7:0]  dout;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   function automatic exp_t mk(int own, logic [22:0] a, logic we, logic [7:0] d, logic [7:0] r);
      exp_t e;
      e.own  = own;
      e.addr = a;
      e.we   = we;
      e.din  = d;
      e.dout = r;
      return e;
   endfunction

   // SDRAM contents as seen by the bench's controller model.
   function automatic logic [7:0] model_rd(logic [22:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h7C;
   endfunction

   int withhold  = 0;
   int ack_delay = 0;

   // SDRAM controller model: acks ack_delay cycles into WAIT_ACK unless withheld.
   initial begin
      logic [22:0] a;
      mem_ack_i  = 1'b0;
      mem_dout_i = 8'h00;
      forever begin
         @(negedge clk_sys);
         if (mem_req_o && !reset) begin
            a = mem_addr_o;
            @(negedge clk_sys);
            repeat (ack_delay) @(negedge clk_sys);
            if (withhold == 0) begin
               mem_ack_i  = 1'b1;
               mem_dout_i = model_rd(a);
               @(negedge clk_sys);
               mem_ack_i  = 1'b0;
               mem_dout_i = 8'h00;
            end
         end
      end
   end

   int mon_own;

   always @(negedge clk_sys) begin
      if (!reset) begin
         if (mem_req_o) begin
            if (sb_q.size() == 0) begin
               check_val("mem_req_unexpected", 32'd1, 32'd0);
            end else begin
               check_val("mem_addr", 32'(mem_addr_o), 32'(sb_q[0].addr));
               check_val("mem_we", 32'(mem_we_o), 32'(sb_q[0].we));
               if (sb_q[0].we) check_val("mem_din", 32'(mem_din_o), 32'(sb_q[0].din));
            end
         end
         if (vid_ack_o || ldr_ack_o || cpu_ack_o) begin
            mon_own = vid_ack_o ? 0 : (ldr_ack_o ? 1 : 2);
            check_val("ack_onehot", 32'(vid_ack_o) + 32'(ldr_ack_o) + 32'(cpu_ack_o), 32'd1);
            if (sb_q.size() == 0) begin
               check_val("ack_unexpected", 32'd1, 32'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check_val("ack_owner", 32'(mon_own), 32'(sb_e.own));
               if (mon_own == 0) check_val("vid_dout", 32'(vid_dout_o), 32'(sb_e.dout));
               if (mon_own == 2) check_val("cpu_dout", 32'(cpu_dout_o), 32'(sb_e.dout));
               $display("txn owner=%0d addr=%06h we=%0d vid_dout=%02h cpu_dout=%02h",
                        mon_own, sb_e.addr, sb_e.we, vid_dout_o, cpu_dout_o);
            end
         end
      end
   end

   task automatic wait_ack(input int budget, output int own, output int cyc);
      own = -1;
      cyc = 0;
      while ((own < 0) && (cyc < budget)) begin
         @(negedge clk_sys);
         cyc++;
         if (vid_ack_o)      own = 0;
         else if (ldr_ack_o) own = 1;
         else if (cpu_ack_o) own = 2;
      end
      if (own < 0) check_val("ack_wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic drop(input int own);
      if (own == 0) vid_req_i = 1'b0;
      if (own == 1) ldr_req_i = 1'b0;
      if (own == 2) cpu_req_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int own, cyc, vcnt, vbefore, acks;
      int cnt[3];

      reset      = 1'b1;
      vid_req_i  = 1'b0;
      vid_addr_i = '0;
      ldr_req_i  = 1'b0;
      ldr_addr_i = '0;
      ldr_din_i  = '0;
      cpu_req_i  = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_addr_i = '0;
      cpu_din_i  = '0;
      repeat (3) @(negedge clk_sys);

      check_val("rst_strobes", 32'({vid_ack_o, ldr_ack_o, cpu_ack_o, mem_req_o}), 32'd0);
      check_val("rst_mem_we", 32'(mem_we_o), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr_o), 32'd0);
      check_val("rst_mem_din", 32'(mem_din_o), 32'd0);
      check_val("rst_douts", 32'({vid_dout_o, cpu_dout_o}), 32'd0);
      check_val("rst_err", 32'(err_timeout_o), 32'd0);
      check_val("rst_wait_n", 32'(cpu_wait_n_o), 32'd1);
      reset = 1'b0;
      @(negedge clk_sys);

      // CPU read with mem_ack in the first WAIT_ACK cycle.
      sb_q.push_back(mk(2, 23'h001234, 1'b0, 8'h00, 8'h5A));
      cpu_addr_i = 16'h1234;
      cpu_we_i   = 1'b0;
      cpu_req_i  = 1'b1;
      #1;
      check_val("t1_wait_n_low", 32'(cpu_wait_n_o), 32'd0);
      wait_ack(20, own, cyc);
      check_val("t1_owner", 32'(own), 32'd2);
      check_val("t1_latency_cycles", 32'(cyc + 1), 32'd4);
      check_val("t1_wait_n_at_ack", 32'(cpu_wait_n_o), 32'd1);
      cpu_req_i = 1'b0;
      @(negedge clk_sys);
      check_val("t1_dout_hold", 32'(cpu_dout_o), 32'h5A);

      // Video streaming with the CPU waiting: 4 video grants, then the CPU.
      vid_addr_i = 14'h0100;
      cpu_addr_i = 16'h2000;
      cpu_we_i   = 1'b0;
      for (int k = 0; k < 4; k++) sb_q.push_back(mk(0, 23'h00C100, 1'b0, 8'h00, model_rd(23'h00C100)));
      sb_q.push_back(mk(2, 23'h002000, 1'b0, 8'h00, model_rd(23'h002000)));
      sb_q.push_back(mk(0, 23'h00C100, 1'b0, 8'h00, model_rd(23'h00C100)));
      vid_req_i = 1'b1;
      cpu_req_i = 1'b1;
      vcnt      = 0;
      vbefore   = -1;
      for (int k = 0; k < 6; k++) begin
         wait_ack(40, own, cyc);
         if (own == 0) vcnt++;
         if (own == 2) begin
            vbefore   = vcnt;
            cpu_req_i = 1'b0;
         end
         if (vcnt >= 5) vid_req_i = 1'b0;
      end
      vid_req_i = 1'b0;
      cpu_req_i = 1'b0;
      repeat (4) @(negedge clk_sys);
      check_val("t2_vid_before_cpu", 32'(vbefore), 32'd4);
      check_val("t2_vid_total", 32'(vcnt), 32'd5);
      check_val("t2_sb_empty", 32'(sb_q.size()), 32'd0);

      // Three simultaneous requests, controller acking 2 cycles late.
      ack_delay  = 2;
      vid_addr_i = 14'h0005;
      ldr_addr_i = 23'h123456;
      ldr_din_i  = 8'h3C;
      cpu_addr_i = 16'h4000;
      cpu_we_i   = 1'b1;
      cpu_din_i  = 8'h99;
      sb_q.push_back(mk(0, 23'h00C005, 1'b0, 8'h00, model_rd(23'h00C005)));
      sb_q.push_back(mk(1, 23'h123456, 1'b1, 8'h3C, 8'h00));
      sb_q.push_back(mk(2, 23'h004000, 1'b1, 8'h99, model_rd(23'h004000)));
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      vid_req_i = 1'b1;
      ldr_req_i = 1'b1;
      cpu_req_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(60, own, cyc);
         if (own >= 0) begin
            cnt[own]++;
            drop(own);
         end
      end
      vid_req_i = 1'b0;
      ldr_req_i = 1'b0;
      cpu_req_i = 1'b0;
      repeat (10) @(negedge clk_sys);
      check_val("t3_vid_acks", 32'(cnt[0]), 32'd1);
      check_val("t3_ldr_acks", 32'(cnt[1]), 32'd1);
      check_val("t3_cpu_acks", 32'(cnt[2]), 32'd1);
      ack_delay = 0;

      // Address-map corners: top of the VRAM window and top of SDRAM.
      vid_addr_i = 14'h3FFF;
      sb_q.push_back(mk(0, 23'h00FFFF, 1'b0, 8'h00, model_rd(23'h00FFFF)));
      vid_req_i = 1'b1;
      wait_ack(20, own, cyc);
      vid_req_i = 1'b0;
      check_val("t4_vid_owner", 32'(own), 32'd0);
      ldr_addr_i = 23'h7FFFFF;
      ldr_din_i  = 8'hA5;
      sb_q.push_back(mk(1, 23'h7FFFFF, 1'b1, 8'hA5, 8'h00));
      ldr_req_i = 1'b1;
      wait_ack(20, own, cyc);
      ldr_req_i = 1'b0;
      check_val("t4_ldr_owner", 32'(own), 32'd1);
      check_val("t4_mem_we", 32'(mem_we_o), 32'd1);
      check_val("t4_mem_din", 32'(mem_din_o), 32'hA5);
      @(negedge clk_sys);

      // Controller never acks: abort returns 0xFF and sets the sticky error.
      withhold   = 1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 16'h0042;
      sb_q.push_back(mk(2, 23'h000042, 1'b0, 8'h00, 8'hFF));
      cpu_req_i = 1'b1;
      wait_ack(600, own, cyc);
      cpu_req_i = 1'b0;
      check_val("t5_owner", 32'(own), 32'd2);
      check_val("t5_not_early", 32'(cyc >= 256), 32'd1);
      check_val("t5_err", 32'(err_timeout_o), 32'd1);
      check_val("t5_dout_ff", 32'(cpu_dout_o), 32'hFF);
      withhold = 0;
      @(negedge clk_sys);
      cpu_addr_i = 16'h0043;
      sb_q.push_back(mk(2, 23'h000043, 1'b0, 8'h00, model_rd(23'h000043)));
      cpu_req_i = 1'b1;
      wait_ack(20, own, cyc);
      cpu_req_i = 1'b0;
      check_val("t5_err_sticky", 32'(err_timeout_o), 32'd1);

      // Reset in WAIT_ACK, then a stray mem_ack afterwards.
      withhold   = 1;
      cpu_addr_i = 16'h0077;
      sb_q.push_back(mk(2, 23'h000077, 1'b0, 8'h00, 8'h00));
      cpu_req_i = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset     = 1'b1;
      cpu_req_i = 1'b0;
      sb_q.delete();
      #1;
      check_val("t6_rst_strobes", 32'({vid_ack_o, ldr_ack_o, cpu_ack_o, mem_req_o}), 32'd0);
      check_val("t6_rst_err", 32'(err_timeout_o), 32'd0);
      check_val("t6_rst_wait_n", 32'(cpu_wait_n_o), 32'd1);
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      mem_ack_i  = 1'b1;
      mem_dout_i = 8'hEE;
      @(negedge clk_sys);
      mem_ack_i  = 1'b0;
      mem_dout_i = 8'h00;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_sys);
         if (vid_ack_o || ldr_ack_o || cpu_ack_o || mem_req_o) acks++;
      end
      check_val("t6_no_activity", 32'(acks), 32'd0);
      check_val("t6_cpu_dout", 32'(cpu_dout_o), 32'h00);
      withhold = 0;
      sb_q.push_back(mk(2, 23'h000077, 1'b0, 8'h00, model_rd(23'h000077)));
      cpu_req_i = 1'b1;
      wait_ack(20, own, cyc);
      cpu_req_i = 1'b0;
      check_val("t6_post_rst_latency", 32'(cyc + 1), 32'd4);

      repeat (4) @(negedge clk_sys);
      check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
